p405s_itlb_refillctl: RTL

Refill and invalidate sequencer for the 4-word instruction shadow TLB (ITLB). It qualifies ITLB misses, requests a translation from the unified TLB (UTLB) over a req/ack handshake, and selects the victim word. It drives the ITLB's word-select, read/write, invalidate and abort controls, and sweeps all four words on reset and on context-synchronising invalidates. It sits between instruction fetch, the ITLB array and the UTLB.

---
 rtl/p405s_itlbCtl_pkg.sv | 29 ++
 rtl/p405s_itlbCtl_victim.sv | 24 ++
 rtl/p405s_itlb_refillctl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/p405s_itlbCtl_pkg.sv
`default_nettype none
// ============================================================================
// p405s_itlbCtl_pkg
// Shared types and sizing for the ITLB refill/invalidate sequencer.
// Revision: 1.0
// ============================================================================
package p405s_itlbCtl_pkg;

  localparam int NWORDS = 4;
  localparam int IDX_W  = 2;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [5:0] {
    ST_IDLE  = 6'b000001,
    ST_INVAL = 6'b000010,
    ST_REQ   = 6'b000100,
    ST_WRITE = 6'b001000,
    ST_DONE  = 6'b010000,
    ST_FAULT = 6'b100000
  } state_t;

  // Next word index, wrapping 3 -> 0.
  function automatic idx_t idx_inc(input idx_t i);
    return i + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/p405s_itlbCtl_victim.sv
`default_nettype none
// ============================================================================
// p405s_itlbCtl_victim
// Victim word select: lowest invalid word, or the round-robin pointer when full.
// Revision: 1.0
// ============================================================================
module p405s_itlbCtl_victim
  import p405s_itlbCtl_pkg::*;
(
  input  logic [NWORDS-1:0] i_valid,
  input  logic [IDX_W-1:0]  i_rrPtr,
  output logic [IDX_W-1:0]  o_victim
);

  always_comb begin
    o_victim = i_rrPtr;
    if (!i_valid[0])      o_victim = 2'd0;
    else if (!i_valid[1]) o_victim = 2'd1;
    else if (!i_valid[2]) o_victim = 2'd2;
    else if (!i_valid[3]) o_victim = 2'd3;
  end

endmodule
`default_nettype wire

// File: rtl/p405s_itlb_refillctl.sv
`default_nettype none
// ============================================================================
// p405s_itlb_refillctl
// ITLB miss qualification, UTLB refill handshake and shadow-word invalidate sweep.
// Revision: 1.0
// ============================================================================
module p405s_itlb_refillctl
  import p405s_itlbCtl_pkg::*;
#(
  parameter int NWORDS = p405s_itlbCtl_pkg::NWORDS
) (
  input  logic             i_CB,
  input  logic             i_resetCore,
  input  logic             i_ifetchValid,
  input  logic             i_VCT_msrIR,
  input  logic             i_itlbMiss,
  input  logic             i_isyncInv,
  input  logic             i_flushAbort,
  input  logic             i_utlbAck,
  input  logic             i_utlbHit,
  output logic             o_utlbReq,
  output logic [IDX_W-1:0] o_isAddr,
  output logic             o_isrdNotWrt,
  output logic             o_isInvalidate,
  output logic             o_isAbort,
  output logic             o_refillBusy,
  output logic             o_itlbFault
);

  state_t            r_state, w_nstate;
  idx_t              r_cnt, w_cnt_n;
  logic [NWORDS-1:0] r_valid, w_valid_n;
  idx_t              r_rrPtr, w_rrPtr_n;
  logic              r_invPend, w_invPend_n;
  logic              r_cancel, w_cancel_n;

  logic              r_utlbReq, w_utlbReq_n;
  idx_t              r_isAddr, w_isAddr_n;
  logic              r_isrdNotWrt, w_isrdNotWrt_n;
  logic              r_isInvalidate, w_isInvalidate_n;
  logic              r_refillBusy, w_refillBusy_n;

  idx_t              w_victim;
  logic              w_missQual;
  logic              w_cancelNow;

  assign w_missQual  = i_itlbMiss & i_ifetchValid & i_VCT_msrIR;
  assign w_cancelNow = r_cancel | i_flushAbort | i_isyncInv;

  p405s_itlbCtl_victim u_victim (
    .i_valid  (r_valid),
    .i_rrPtr  (r_rrPtr),
    .o_victim (w_victim)
  );

  always_ff @(posedge i_CB or posedge i_resetCore) begin
    if (i_resetCore) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_valid        <= '0;
      r_rrPtr        <= '0;
      r_invPend      <= 1'b1;
      r_cancel       <= 1'b0;
      r_utlbReq      <= 1'b0;
      r_isAddr       <= '0;
      r_isrdNotWrt   <= 1'b1;
      r_isInvalidate <= 1'b0;
      r_refillBusy   <= 1'b0;
    end else begin
      r_state        <= w_nstate;
      r_cnt          <= w_cnt_n;
      r_valid        <= w_valid_n;
      r_rrPtr        <= w_rrPtr_n;
      r_invPend      <= w_invPend_n;
      r_cancel       <= w_cancel_n;
      r_utlbReq      <= w_utlbReq_n;
      r_isAddr       <= w_isAddr_n;
      r_isrdNotWrt   <= w_isrdNotWrt_n;
      r_isInvalidate <= w_isInvalidate_n;
      r_refillBusy   <= w_refillBusy_n;
    end
  end

  always_comb begin
    w_nstate         = r_state;
    w_cnt_n          = r_cnt;
    w_valid_n        = r_valid;
    w_rrPtr_n        = r_rrPtr;
    // An isync pulse in any state leaves a sweep pending.
    w_invPend_n      = r_invPend | i_isyncInv;
    w_cancel_n       = r_cancel;
    w_utlbReq_n      = 1'b0;
    w_isAddr_n       = '0;
    w_isrdNotWrt_n   = 1'b1;
    w_isInvalidate_n = 1'b0;
    w_refillBusy_n   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (r_invPend || i_isyncInv) begin
          w_nstate = ST_INVAL;
          w_cnt_n  = '0;
        end else if (w_missQual) begin
          w_nstate   = ST_REQ;
          w_cancel_n = 1'b0;
        end
      end
      ST_INVAL: begin
        w_valid_n[r_cnt] = 1'b0;
        if (r_cnt == 2'd3) begin
          w_invPend_n = i_isyncInv;
          w_nstate    = ST_IDLE;
        end else begin
          w_cnt_n = idx_inc(r_cnt);
        end
      end
      ST_REQ: begin
        w_cancel_n = w_cancelNow;
        if (i_utlbAck) begin
          if (w_cancelNow)    w_nstate = ST_IDLE;
          else if (i_utlbHit) w_nstate = ST_WRITE;
          else                w_nstate = ST_FAULT;
        end
      end
      ST_WRITE: begin
        // r_isAddr still holds the victim captured on entry to WRITE.
        if (!i_flushAbort) begin
          w_valid_n[r_isAddr] = 1'b1;
          w_rrPtr_n           = idx_inc(r_isAddr);
        end
        w_nstate = ST_DONE;
      end
      ST_DONE:  w_nstate = ST_IDLE;
      ST_FAULT: w_nstate = ST_IDLE;
      default:  w_nstate = ST_IDLE;
    endcase

    // Outputs are registered from the state being entered.
    case (w_nstate)
      ST_INVAL: begin
        w_isAddr_n       = w_cnt_n;
        w_isInvalidate_n = 1'b1;
        w_refillBusy_n   = 1'b1;
      end
      ST_REQ: begin
        w_utlbReq_n    = 1'b1;
        w_refillBusy_n = 1'b1;
      end
      ST_WRITE: begin
        w_isAddr_n     = w_victim;
        w_isrdNotWrt_n = 1'b0;
        w_refillBusy_n = 1'b1;
      end
      ST_DONE:  w_refillBusy_n = 1'b1;
      ST_FAULT: w_refillBusy_n = 1'b1;
      default:  w_refillBusy_n = 1'b0;
    endcase
  end

  assign o_utlbReq      = r_utlbReq;
  assign o_isAddr       = r_isAddr;
  assign o_isrdNotWrt   = r_isrdNotWrt;
  assign o_isInvalidate = r_isInvalidate;
  assign o_refillBusy   = r_refillBusy;

  // Abort and fault must react to a flush in the very cycle they are presented,
  // so they gate a registered state bit with the live flush input.
  assign o_isAbort   = (r_state == ST_WRITE) & i_flushAbort;
  assign o_itlbFault = (r_state == ST_FAULT) & ~i_flushAbort;

endmodule
`default_nettype wire
